// File: rtl/multicycle_shifter.sv
// Multi-cycle shift unit: SLL/SRL/SRA/ROL by a runtime amount,
// STEP bit positions per cycle, valid/ready on both sides.
module multicycle_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W:0] WK = (SHAMT_W+1)'(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   data;
  logic [WIDTH-1:0]   nxt;
  logic [WIDTH-1:0]   fill;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] k;
  logic [SHAMT_W:0]   rk;
  logic [1:0]         mode;
  logic               sign;
  logic               ready_q;

  assign in_ready = ready_q & rst_n;

  // The final step shrinks to the remaining count so nothing overshoots.
  always_comb begin
    k = rem;
    if (32'(rem) > 32'(STEP))
      k = SHAMT_W'(STEP);
    rk   = WK - {1'b0, k};
    fill = sign ? ~({WIDTH{1'b1}} >> k) : '0;
    nxt  = data;
    unique case (mode)
      2'b00: nxt = data << k;
      2'b01: nxt = data >> k;
      2'b10: nxt = (data >> k) | fill;
      2'b11: nxt = (data << k) | (data >> rk);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= '0;
      rem       <= '0;
      mode      <= '0;
      sign      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data    <= in_data;
            mode    <= in_mode;
            rem     <= in_shamt;
            sign    <= in_data[WIDTH-1];
            ready_q <= 1'b0;
            busy    <= 1'b1;
            if (in_shamt == '0) begin
              state     <= DONE;
              out_data  <= in_data;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data <= nxt;
          rem  <= rem - k;
          if (rem == k) begin
            state     <= DONE;
            out_data  <= nxt;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_shifter.sv
// Bench for multicycle_shifter: STEP=1 and STEP=4 instances,
// directed table, handshake corner sequences, random sweep.
module tb_multicycle_shifter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       iv, ir, ov, ordy, bsy;
  logic [1:0][31:0] id, od;
  logic [1:0][4:0]  sh;
  logic [1:0][1:0]  md;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .in_shamt(sh[0]), .in_mode(md[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .busy(bsy[0])
  );

  multicycle_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .in_shamt(sh[1]), .in_mode(md[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .busy(bsy[1])
  );

  typedef struct {
    int          u;
    logic [1:0]  m;
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] e;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d,
                                        input logic [4:0] s,
                                        input logic [1:0] m);
    case (m)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
    endcase
  endfunction

  function automatic int exp_lat(input int u, input logic [4:0] s);
    int st = (u == 0) ? 1 : 4;
    return (int'(s) + st - 1) / st;
  endfunction

  task automatic wait_ready(input int u);
    int n = 0;
    while (!ir[u] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", 32'(ir[u]), 32'd1);
  endtask

  task automatic run_op(input int u,
                        input logic [31:0] d,
                        input logic [4:0] s,
                        input logic [1:0] m,
                        output logic [31:0] res,
                        output int lat);
    wait_ready(u);
    id[u] = d; sh[u] = s; md[u] = m; iv[u] = 1'b1;
    @(posedge clk); #1;
    iv[u] = 1'b0;
    lat = 0;
    while (!ov[u] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = od[u];
    ordy[u] = 1'b1;
    @(posedge clk); #1;
    ordy[u] = 1'b0;
    check("valid_drop", 32'(ov[u]), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  m;
    int          lat;
    int          u;
    int          seen;

    vecs[0] = '{0, 2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004};
    vecs[1] = '{1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[2] = '{0, 2'b11, 32'h8000_0001, 5'd4,  32'h0000_0018};
    vecs[3] = '{1, 2'b01, 32'h8000_0001, 5'd4,  32'h0800_0000};
    vecs[4] = '{0, 2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[5] = '{1, 2'b10, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF};
    vecs[6] = '{0, 2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[7] = '{1, 2'b11, 32'h1234_5678, 5'd8,  32'h3456_7812};
    vecs[8] = '{1, 2'b10, 32'hF000_0000, 5'd5,  32'hFF80_0000};
    vecs[9] = '{1, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};

    rst_n = 1'b0;
    iv = '0; ordy = '0; id = '0; sh = '0; md = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(ov), 32'd0);
    check("rst_busy",  32'(bsy), 32'd0);
    check("rst_data0", od[0], 32'd0);
    check("rst_data1", od[1], 32'd0);
    check("rst_ready_low", 32'(ir), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_high", 32'(ir), 32'd3);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].u, vecs[i].d, vecs[i].s, vecs[i].m, res, lat);
      check($sformatf("vec%0d_data", i), res, vecs[i].e);
      check($sformatf("vec%0d_lat", i), 32'(lat),
            32'(exp_lat(vecs[i].u, vecs[i].s)));
    end

    // Zero shift, held result, then back-to-back request in DONE.
    wait_ready(0);
    id[0] = 32'h1234_5678; sh[0] = 5'd0; md[0] = 2'b01;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    check("z_valid", 32'(ov[0]), 32'd1);
    check("z_data", od[0], 32'h1234_5678);
    id[0] = 32'hDEAD_BEEF; sh[0] = 5'd4; md[0] = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_data", c), od[0], 32'h1234_5678);
      check($sformatf("hold%0d_valid", c), 32'(ov[0]), 32'd1);
      check($sformatf("hold%0d_ready", c), 32'(ir[0]), 32'd0);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    check("b2b_valid", 32'(ov[0]), 32'd0);
    check("b2b_ready", 32'(ir[0]), 32'd1);
    check("b2b_busy", 32'(bsy[0]), 32'd0);
    check("b2b_hold", od[0], 32'h1234_5678);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("b2b_accept", 32'(bsy[0]), 32'd1);
    check("b2b_noready", 32'(ir[0]), 32'd0);
    lat = 0;
    while (!ov[0] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat", 32'(lat), 32'd4);
    check("b2b_data", od[0], 32'hEADB_EEF0);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;

    // Reset on the 5th SHIFT edge of a 20-step op.
    wait_ready(0);
    id[0] = 32'h0000_0001; sh[0] = 5'd20; md[0] = 2'b00;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", 32'(bsy[0]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mr_valid", 32'(ov[0]), 32'd0);
    check("mr_data", od[0], 32'd0);
    check("mr_busy", 32'(bsy[0]), 32'd0);
    check("mr_ready_low", 32'(ir[0]), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mr_ready_high", 32'(ir[0]), 32'd1);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (ov[0] || bsy[0]) seen++;
    end
    check("mr_no_stale", 32'(seen), 32'd0);

    for (int i = 0; i < 24; i++) begin
      u = i % 2;
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      m = 2'($urandom_range(0, 3));
      run_op(u, d, s, m, res, lat);
      check($sformatf("rnd%0d_u%0d_m%0d_s%0d", i, u, m, s),
            res, model(d, s, m));
      check($sformatf("rnd%0d_lat", i), 32'(lat),
            32'(exp_lat(u, s)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
